// File: rtl/mc_pkg.sv
// Shared memory-controller types: command record, op encoding and queue sizing.
package mc_pkg;

    localparam int TAG_W     = 3;
    localparam int QDEPTH    = 8;
    localparam int MC_AWIDTH = 32;
    localparam int MC_DWIDTH = 64;

    typedef enum logic {
        MC_WRITE = 1'b0,
        MC_READ  = 1'b1
    } mc_op_e;

    typedef struct packed {
        logic                 rw;
        logic [MC_AWIDTH-1:0] addr;
        logic [MC_DWIDTH-1:0] data;
        logic [TAG_W-1:0]     tag;
    } mc_cmd_t;

endpackage

// File: rtl/cmd_queue_mem.sv
// Command storage for cmd_queue: one synchronous write port, one asynchronous read port.
module cmd_queue_mem
    import mc_pkg::*;
#(
    parameter int DEPTH = QDEPTH,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             wr_en,
    input  logic [PTR_W-1:0] wr_ptr,
    input  mc_cmd_t          wr_cmd,
    input  logic [PTR_W-1:0] rd_ptr,
    output mc_cmd_t          rd_cmd
);

    // Storage is deliberately not reset; occupancy tracking in the parent masks stale entries.
    mc_cmd_t mem [DEPTH];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_cmd;
        end
    end

    assign rd_cmd = mem[rd_ptr];

endmodule

// File: rtl/cmd_queue.sv
// Eight-entry FWFT command queue with tag stamping, back-pressure and sticky overflow.
module cmd_queue
    import mc_pkg::*;
#(
    parameter int AWIDTH = MC_AWIDTH,
    parameter int DWIDTH = MC_DWIDTH,
    parameter int DEPTH  = QDEPTH
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              push_valid,
    input  logic              push_rw,
    input  logic [AWIDTH-1:0] push_addr,
    input  logic [DWIDTH-1:0] push_data,
    output logic              fifo_full,
    output logic [TAG_W-1:0]  tag_gen,
    input  logic              pop_ready,
    output logic              pop_valid,
    output logic              pop_rw,
    output logic [AWIDTH-1:0] pop_addr,
    output logic [DWIDTH-1:0] pop_data,
    output logic [TAG_W-1:0]  pop_tag,
    output logic [3:0]        count,
    output logic              overflow
);

    logic [TAG_W-1:0] wr_ptr;
    logic [TAG_W-1:0] rd_ptr;
    logic             push_accept;
    logic             pop_accept;
    mc_cmd_t          wr_cmd;
    mc_cmd_t          head_cmd;

    // Full/valid come from the registered count only, so a same-cycle pop never frees room for a push.
    assign fifo_full   = (count == 4'(DEPTH));
    assign pop_valid   = (count != 4'd0);
    assign push_accept = push_valid && !fifo_full;
    assign pop_accept  = pop_ready && pop_valid;

    assign wr_cmd.rw   = push_rw;
    assign wr_cmd.addr = push_addr;
    assign wr_cmd.data = push_data;
    assign wr_cmd.tag  = tag_gen;

    cmd_queue_mem #(
        .DEPTH (DEPTH),
        .PTR_W (TAG_W)
    ) u_mem (
        .clock  (clock),
        .wr_en  (push_accept && !reset),
        .wr_ptr (wr_ptr),
        .wr_cmd (wr_cmd),
        .rd_ptr (rd_ptr),
        .rd_cmd (head_cmd)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            tag_gen  <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_accept) begin
                wr_ptr  <= wr_ptr + 1'b1;
                tag_gen <= tag_gen + 1'b1;
            end
            if (pop_accept) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + 4'(push_accept) - 4'(pop_accept);
            if (push_valid && fifo_full) begin
                overflow <= 1'b1;
            end
        end
    end

    // Head fields are forced to zero when empty so stale storage never leaks downstream.
    always_comb begin
        pop_rw   = 1'b0;
        pop_addr = '0;
        pop_data = '0;
        pop_tag  = '0;
        if (pop_valid) begin
            pop_rw   = head_cmd.rw;
            pop_addr = head_cmd.addr;
            pop_data = head_cmd.data;
            pop_tag  = head_cmd.tag;
        end
    end

endmodule

// File: tb/tb_cmd_queue.sv
// Directed self-checking bench for cmd_queue with hand-computed expectations.
module tb_cmd_queue;

    logic        clock = 1'b0;
    logic        reset;
    logic        push_valid;
    logic        push_rw;
    logic [31:0] push_addr;
    logic [63:0] push_data;
    logic        fifo_full;
    logic [2:0]  tag_gen;
    logic        pop_ready;
    logic        pop_valid;
    logic        pop_rw;
    logic [31:0] pop_addr;
    logic [63:0] pop_data;
    logic [2:0]  pop_tag;
    logic [3:0]  count;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    cmd_queue dut (
        .clock      (clock),
        .reset      (reset),
        .push_valid (push_valid),
        .push_rw    (push_rw),
        .push_addr  (push_addr),
        .push_data  (push_data),
        .fifo_full  (fifo_full),
        .tag_gen    (tag_gen),
        .pop_ready  (pop_ready),
        .pop_valid  (pop_valid),
        .pop_rw     (pop_rw),
        .pop_addr   (pop_addr),
        .pop_data   (pop_data),
        .pop_tag    (pop_tag),
        .count      (count),
        .overflow   (overflow)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Drive one cycle of inputs, clock it in, then settle 1 time unit past the edge.
    task automatic applyStimulus(input logic rst, input logic pv, input logic rw,
                                 input logic [31:0] addr, input logic [63:0] data, input logic pr);
        reset      = rst;
        push_valid = pv;
        push_rw    = rw;
        push_addr  = addr;
        push_data  = data;
        pop_ready  = pr;
        @(posedge clock);
        #1;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 64'h0, 1'b0);
    endtask

    task automatic resetCycle();
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 64'h0, 1'b0);
    endtask

    task automatic checkEmptyHead(input string tag);
        checkOutput({tag, ".pop_valid"}, 64'(pop_valid), 64'h0);
        checkOutput({tag, ".pop_rw"},    64'(pop_rw),    64'h0);
        checkOutput({tag, ".pop_addr"},  64'(pop_addr),  64'h0);
        checkOutput({tag, ".pop_data"},  pop_data,       64'h0);
        checkOutput({tag, ".pop_tag"},   64'(pop_tag),   64'h0);
    endtask

    initial begin
        reset = 1'b1; push_valid = 1'b0; push_rw = 1'b0;
        push_addr = '0; push_data = '0; pop_ready = 1'b0;

        // Reset state
        resetCycle();
        resetCycle();
        checkOutput("rst.count",     64'(count),     64'd0);
        checkOutput("rst.fifo_full", 64'(fifo_full), 64'd0);
        checkOutput("rst.tag_gen",   64'(tag_gen),   64'd0);
        checkOutput("rst.overflow",  64'(overflow),  64'd0);
        checkEmptyHead("rst");

        // Single write push
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h100, 64'hA5A5, 1'b0);
        checkOutput("one.pop_valid", 64'(pop_valid), 64'd1);
        checkOutput("one.pop_tag",   64'(pop_tag),   64'd0);
        checkOutput("one.pop_rw",    64'(pop_rw),    64'd0);
        checkOutput("one.pop_addr",  64'(pop_addr),  64'h100);
        checkOutput("one.pop_data",  pop_data,       64'hA5A5);
        checkOutput("one.count",     64'(count),     64'd1);
        checkOutput("one.tag_gen",   64'(tag_gen),   64'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 64'h0, 1'b1);
        checkOutput("one.drain_count", 64'(count), 64'd0);
        checkEmptyHead("one.drain");

        // Fill to full, then a dropped ninth push
        resetCycle();
        for (int i = 0; i < 8; i++) begin
            checkOutput("fill.fifo_full_before", 64'(fifo_full), 64'd0);
            applyStimulus(1'b0, 1'b1, 1'(i), 32'h200 + 32'(i), 64'hD000 + 64'(i), 1'b0);
        end
        checkOutput("fill.count",     64'(count),     64'd8);
        checkOutput("fill.fifo_full", 64'(fifo_full), 64'd1);
        checkOutput("fill.tag_gen",   64'(tag_gen),   64'd0);
        checkOutput("fill.overflow",  64'(overflow),  64'd0);
        checkOutput("fill.head_addr", 64'(pop_addr),  64'h200);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'hDEAD, 64'hDEAD, 1'b0);
        checkOutput("drop.count",    64'(count),    64'd8);
        checkOutput("drop.overflow", 64'(overflow), 64'd1);
        checkOutput("drop.tag_gen",  64'(tag_gen),  64'd0);
        checkOutput("drop.head_tag", 64'(pop_tag),  64'd0);

        // Full with simultaneous push and pop: pop wins, push dropped
        resetCycle();
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 1'b1, 1'(i), 32'h300 + 32'(i), 64'hE000 + 64'(i), 1'b0);
        end
        applyStimulus(1'b0, 1'b1, 1'b1, 32'hBAD, 64'hBAD, 1'b1);
        checkOutput("fpp.count",     64'(count),     64'd7);
        checkOutput("fpp.overflow",  64'(overflow),  64'd1);
        checkOutput("fpp.fifo_full", 64'(fifo_full), 64'd0);
        checkOutput("fpp.tag_gen",   64'(tag_gen),   64'd0);
        for (int i = 1; i < 8; i++) begin
            checkOutput("fpp.drain_tag",  64'(pop_tag),  64'(i));
            checkOutput("fpp.drain_addr", 64'(pop_addr), 64'h300 + 64'(i));
            checkOutput("fpp.drain_rw",   64'(pop_rw),   64'(i % 2));
            checkOutput("fpp.drain_data", pop_data,      64'hE000 + 64'(i));
            applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 64'h0, 1'b1);
        end
        checkOutput("fpp.empty_count", 64'(count), 64'd0);

        // Pop on empty is ignored
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 64'h0, 1'b1);
        checkOutput("epop.count", 64'(count), 64'd0);
        checkEmptyHead("epop");
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h440, 64'h44, 1'b0);
        checkOutput("epop.next_tag",  64'(pop_tag),  64'd0);
        checkOutput("epop.next_addr", 64'(pop_addr), 64'h440);

        // Continuous push and pop for 20 commands
        resetCycle();
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h1000, 64'h0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            checkOutput("stream.count", 64'(count),    64'd1);
            checkOutput("stream.tag",   64'(pop_tag),  64'(i % 8));
            checkOutput("stream.addr",  64'(pop_addr), 64'h1000 + 64'(i));
            applyStimulus(1'b0, 1'b1, 1'b1, 32'h1000 + 32'(i + 1), 64'(i + 1), 1'b1);
        end
        checkOutput("stream.tag_gen", 64'(tag_gen), 64'd5);

        // Reset mid-operation with push and pop in flight
        resetCycle();
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 32'h500 + 32'(i), 64'h0, 1'b0);
        end
        for (int i = 0; i < 3; i++) begin
            idleCycle();
            applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 64'h0, 1'b1);
        end
        checkOutput("mid.count_before",    64'(count),    64'd5);
        checkOutput("mid.overflow_before", 64'(overflow), 64'd1);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h777, 64'h777, 1'b1);
        checkOutput("mid.count",    64'(count),    64'd0);
        checkOutput("mid.tag_gen",  64'(tag_gen),  64'd0);
        checkOutput("mid.overflow", 64'(overflow), 64'd0);
        checkEmptyHead("mid");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
